// File: rtl/cdb_arbiter_if.sv
// Bundle of the producer push ports, the stall backpressure and the shared
// result broadcast port of the common-data-bus arbiter.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 readyIn;
  logic                 clearIn;
  logic                 aluValid;
  logic [ROB_WIDTH-1:0] aluRobIndex;
  logic [31:0]          aluVal;
  logic                 aluStall;
  logic                 lsbValid;
  logic [ROB_WIDTH-1:0] lsbRobIndex;
  logic [31:0]          lsbVal;
  logic                 lsbStall;
  logic                 cdbValid;
  logic [ROB_WIDTH-1:0] cdbRobIndex;
  logic [31:0]          cdbVal;
  logic                 cdbSource;
  logic                 overflowErr;

  modport slave (
    input  readyIn, clearIn,
    input  aluValid, aluRobIndex, aluVal,
    input  lsbValid, lsbRobIndex, lsbVal,
    output aluStall, lsbStall,
    output cdbValid, cdbRobIndex, cdbVal, cdbSource, overflowErr
  );

  modport master (
    output readyIn, clearIn,
    output aluValid, aluRobIndex, aluVal,
    output lsbValid, lsbRobIndex, lsbVal,
    input  aluStall, lsbStall,
    input  cdbValid, cdbRobIndex, cdbVal, cdbSource, overflowErr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two small per-source result FIFOs (index 0 = ALU,
// index 1 = LSB) drained round-robin onto one registered broadcast port.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_WIDTH = 1
) (
  input  logic          clockIn,
  input  logic          resetIn,
  cdb_arbiter_if.slave  bus
);
  localparam int DEPTH = 2 ** FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   CNT_FULL = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = FIFO_WIDTH'(1);

  logic [ROB_WIDTH-1:0]  rob_mem [2][DEPTH];
  logic [31:0]           val_mem [2][DEPTH];
  logic [FIFO_WIDTH-1:0] head [2];
  logic [FIFO_WIDTH-1:0] tail [2];
  logic [FIFO_WIDTH:0]   count [2];
  logic                  last_grant;

  logic                  cdb_valid;
  logic [ROB_WIDTH-1:0]  cdb_rob;
  logic [31:0]           cdb_val;
  logic                  cdb_source;
  logic                  overflow;

  logic [1:0]            in_valid;
  logic [ROB_WIDTH-1:0]  in_rob [2];
  logic [31:0]           in_val [2];
  logic [1:0]            stall;
  logic [1:0]            non_empty;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic                  active;
  logic                  grant_any;
  logic                  grant;

  // Gather both producers into indexable form and decide pushes, stalls and the grant.
  // Stall and candidacy only look at registered counts, so a same-cycle pop never
  // releases a stall and a same-cycle push is never broadcast immediately.
  always_comb begin
    in_valid  = {bus.lsbValid, bus.aluValid};
    in_rob[0] = bus.aluRobIndex;
    in_rob[1] = bus.lsbRobIndex;
    in_val[0] = bus.aluVal;
    in_val[1] = bus.lsbVal;
    active    = bus.readyIn && !bus.clearIn;
    for (int s = 0; s < 2; s++) begin
      stall[s]     = (count[s] == CNT_FULL);
      non_empty[s] = (count[s] != '0);
    end
    grant_any = |non_empty;
    if (non_empty == 2'b11) begin
      grant = ~last_grant;
    end else begin
      grant = non_empty[1];
    end
    push = active ? (in_valid & ~stall) : 2'b00;
    pop  = 2'b00;
    if (active && grant_any) begin
      pop[grant] = 1'b1;
    end
  end

  // FIFO bookkeeping, broadcast register and sticky overflow; reset beats flush beats freeze.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      cdb_valid  <= 1'b0;
      cdb_rob    <= '0;
      cdb_val    <= '0;
      cdb_source <= 1'b0;
      overflow   <= 1'b0;
      last_grant <= 1'b1;
    end else if (bus.clearIn) begin
      for (int s = 0; s < 2; s++) begin
        head[s]  <= '0;
        tail[s]  <= '0;
        count[s] <= '0;
      end
      cdb_valid <= 1'b0;
    end else if (bus.readyIn) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          rob_mem[s][tail[s]] <= in_rob[s];
          val_mem[s][tail[s]] <= in_val[s];
          tail[s]             <= tail[s] + PTR_ONE;
        end
        if (pop[s]) begin
          head[s] <= head[s] + PTR_ONE;
        end
        case ({push[s], pop[s]})
          2'b10:   count[s] <= count[s] + CNT_ONE;
          2'b01:   count[s] <= count[s] - CNT_ONE;
          default: count[s] <= count[s];
        endcase
      end
      if ((in_valid & stall) != 2'b00) begin
        overflow <= 1'b1;
      end
      if (grant_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob    <= rob_mem[grant][head[grant]];
        cdb_val    <= val_mem[grant][head[grant]];
        cdb_source <= grant;
        last_grant <= grant;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  assign bus.aluStall    = stall[0];
  assign bus.lsbStall    = stall[1];
  assign bus.cdbValid    = cdb_valid;
  assign bus.cdbRobIndex = cdb_rob;
  assign bus.cdbVal      = cdb_val;
  assign bus.cdbSource   = cdb_source;
  assign bus.overflowErr = overflow;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, a contention sequence, and a
// randomized run against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  cdb_arbiter_if #(.ROB_WIDTH(4)) bus ();

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_WIDTH(1)) dut (
    .clockIn (clk),
    .resetIn (rst_n),
    .bus     (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, clr;
    logic        av;  logic [3:0] ar; logic [31:0] avl;
    logic        lv;  logic [3:0] lr; logic [31:0] lvl;
    logic        ev;  logic [3:0] er; logic [31:0] ed; logic es;
    logic        eas, els, eof;
  } vec_t;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
  } ent_t;

  vec_t vec[$];

  ent_t aq[$];
  ent_t lq[$];
  logic        m_valid, m_src, m_of, m_last;
  logic [3:0]  m_rob;
  logic [31:0] m_val;

  function automatic vec_t mk(input logic rst, rdy, clr,
                              input logic av, input logic [3:0] ar, input logic [31:0] avl,
                              input logic lv, input logic [3:0] lr, input logic [31:0] lvl,
                              input logic ev, input logic [3:0] er, input logic [31:0] ed,
                              input logic es, input logic eas, input logic els, input logic eof);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.clr = clr;
    v.av = av; v.ar = ar; v.avl = avl;
    v.lv = lv; v.lr = lr; v.lvl = lvl;
    v.ev = ev; v.er = er; v.ed = ed; v.es = es;
    v.eas = eas; v.els = els; v.eof = eof;
    return v;
  endfunction

  task automatic apply_stimulus(input logic rst, rdy, clr,
                                input logic av, input logic [3:0] ar, input logic [31:0] avl,
                                input logic lv, input logic [3:0] lr, input logic [31:0] lvl);
    rst_n           = rst;
    bus.readyIn     = rdy;
    bus.clearIn     = clr;
    bus.aluValid    = av;
    bus.aluRobIndex = ar;
    bus.aluVal      = avl;
    bus.lsbValid    = lv;
    bus.lsbRobIndex = lr;
    bus.lsbVal      = lvl;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: two queues, round robin by the spec's rules, evaluated on
  // the inputs that will be sampled at the coming edge.
  task automatic model_step(input logic rst, rdy, clr,
                            input logic av, input logic [3:0] ar, input logic [31:0] avl,
                            input logic lv, input logic [3:0] lr, input logic [31:0] lvl);
    int   na, nl;
    logic g;
    ent_t e;
    if (!rst) begin
      aq.delete(); lq.delete();
      m_valid = 0; m_rob = 0; m_val = 0; m_src = 0; m_of = 0; m_last = 1;
    end else if (clr) begin
      aq.delete(); lq.delete();
      m_valid = 0;
    end else if (rdy) begin
      na = aq.size();
      nl = lq.size();
      if ((av && na == D) || (lv && nl == D)) m_of = 1;
      if (na > 0 || nl > 0) begin
        g = (na > 0 && nl > 0) ? !m_last : (nl > 0);
        e = g ? lq.pop_front() : aq.pop_front();
        m_valid = 1; m_rob = e.rob; m_val = e.val; m_src = g; m_last = g;
      end else begin
        m_valid = 0;
      end
      if (av && na < D) aq.push_back({ar, avl});
      if (lv && nl < D) lq.push_back({lr, lvl});
    end
  endtask

  initial begin
    int sa, sl, got, ga, gl;
    logic        rst, rdy, clr, av, lv;
    logic [3:0]  ar, lr;
    logic [31:0] avl, lvl;

    // rst rdy clr | av ar avl | lv lr lvl | ev er ed es | as ls of
    vec.push_back(mk(0,1,0, 0,0,0,       0,0,0,       0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 1,3,'h11,    0,0,0,       0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,3,'h11,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,3,'h11,0,    0,0,0));
    vec.push_back(mk(0,1,0, 0,0,0,       0,0,0,       0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 1,1,'hA,     1,2,'hB,     0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,1,'hA,0,     0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,2,'hB,1,     0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,2,'hB,1,     0,0,0));
    vec.push_back(mk(1,1,0, 1,4,'h40,    1,5,'h50,    0,2,'hB,1,     0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       1,6,'h60,    1,4,'h40,0,    0,1,0));
    vec.push_back(mk(1,1,0, 0,0,0,       1,7,'h70,    1,5,'h50,1,    0,0,1));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,6,'h60,1,    0,0,1));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,6,'h60,1,    0,0,1));
    vec.push_back(mk(0,1,0, 0,0,0,       0,0,0,       0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 1,8,'h80,    1,9,'h90,    0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 1,10,'hA0,   1,11,'hB0,   1,8,'h80,0,    0,1,0));
    vec.push_back(mk(1,1,0, 1,12,'hC0,   0,0,0,       1,9,'h90,1,    1,0,0));
    vec.push_back(mk(1,1,1, 1,13,'hD0,   1,14,'hE0,   0,9,'h90,1,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,9,'h90,1,    0,0,0));
    vec.push_back(mk(1,1,0, 1,5,'h55,    0,0,0,       0,9,'h90,1,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,5,'h55,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,5,'h55,0,    0,0,0));
    vec.push_back(mk(1,1,0, 1,6,'h66,    1,7,'h77,    0,5,'h55,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,7,'h77,1,    0,0,0));
    vec.push_back(mk(1,0,0, 1,1,'h1,     1,2,'h2,     1,7,'h77,1,    0,0,0));
    vec.push_back(mk(1,0,0, 1,1,'h1,     1,2,'h2,     1,7,'h77,1,    0,0,0));
    vec.push_back(mk(1,0,0, 1,1,'h1,     1,2,'h2,     1,7,'h77,1,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,6,'h66,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,6,'h66,0,    0,0,0));
    vec.push_back(mk(1,1,0, 1,3,'h33,    1,4,'h44,    0,6,'h66,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,4,'h44,1,    0,0,0));
    vec.push_back(mk(0,1,0, 1,15,'hFF,   1,15,'hFF,   0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 1,9,'h99,    1,8,'h88,    0,0,0,0,       0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,9,'h99,0,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       1,8,'h88,1,    0,0,0));
    vec.push_back(mk(1,1,0, 0,0,0,       0,0,0,       0,8,'h88,1,    0,0,0));

    // Directed vector table, one row per clock edge.
    for (int i = 0; i < vec.size(); i++) begin
      apply_stimulus(vec[i].rst, vec[i].rdy, vec[i].clr,
                     vec[i].av, vec[i].ar, vec[i].avl,
                     vec[i].lv, vec[i].lr, vec[i].lvl);
      @(posedge clk);
      #1;
      check_output($sformatf("row%0d cdbValid", i),    bus.cdbValid,    vec[i].ev);
      check_output($sformatf("row%0d cdbRobIndex", i), bus.cdbRobIndex, vec[i].er);
      check_output($sformatf("row%0d cdbVal", i),      bus.cdbVal,      vec[i].ed);
      check_output($sformatf("row%0d cdbSource", i),   bus.cdbSource,   vec[i].es);
      check_output($sformatf("row%0d aluStall", i),    bus.aluStall,    vec[i].eas);
      check_output($sformatf("row%0d lsbStall", i),    bus.lsbStall,    vec[i].els);
      check_output($sformatf("row%0d overflowErr", i), bus.overflowErr, vec[i].eof);
    end

    // Contention: both sources push 4 entries each, only when not stalled.
    apply_stimulus(0,1,0, 0,0,0, 0,0,0);
    @(posedge clk);
    #1;
    sa = 0; sl = 0; got = 0; ga = 0; gl = 0;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      av = (sa < 4) && !bus.aluStall;
      lv = (sl < 4) && !bus.lsbStall;
      apply_stimulus(1,1,0, av, 4'(sa), 32'h100 + sa, lv, 4'(8 + sl), 32'h200 + sl);
      if (av) sa++;
      if (lv) sl++;
      @(posedge clk);
      #1;
      if (bus.cdbValid) begin
        check_output($sformatf("fair%0d cdbSource", got), bus.cdbSource, got % 2);
        if (bus.cdbSource) begin
          check_output($sformatf("fair%0d lsb order", got), bus.cdbRobIndex, 8 + gl);
          gl++;
        end else begin
          check_output($sformatf("fair%0d alu order", got), bus.cdbRobIndex, ga);
          ga++;
        end
        got++;
      end
    end
    check_output("fair broadcast count", got, 8);
    check_output("fair overflowErr", bus.overflowErr, 0);

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      rst = (i == 0) || ($urandom_range(0, 99) >= 1);
      rst = (i == 0) ? 1'b0 : rst;
      rdy = ($urandom_range(0, 99) >= 10);
      clr = ($urandom_range(0, 99) < 3);
      av  = ($urandom_range(0, 99) < 55);
      lv  = ($urandom_range(0, 99) < 55);
      ar  = 4'($urandom);
      lr  = 4'($urandom);
      avl = $urandom;
      lvl = $urandom;
      apply_stimulus(rst, rdy, clr, av, ar, avl, lv, lr, lvl);
      model_step(rst, rdy, clr, av, ar, avl, lv, lr, lvl);
      @(posedge clk);
      #1;
      check_output($sformatf("rnd%0d cdbValid", i),    bus.cdbValid,    m_valid);
      check_output($sformatf("rnd%0d cdbRobIndex", i), bus.cdbRobIndex, m_rob);
      check_output($sformatf("rnd%0d cdbVal", i),      bus.cdbVal,      m_val);
      check_output($sformatf("rnd%0d cdbSource", i),   bus.cdbSource,   m_src);
      check_output($sformatf("rnd%0d aluStall", i),    bus.aluStall,    aq.size() == D);
      check_output($sformatf("rnd%0d lsbStall", i),    bus.lsbStall,    lq.size() == D);
      check_output($sformatf("rnd%0d overflowErr", i), bus.overflowErr, m_of);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
